// File: rtl/ipsxe_floating_point_axi4s_join_v1_0.sv
// AXI4-Stream operand join: per-channel FIFOs popped together into one registered joined beat.
// Latency 1 cycle from the last channel's FIFO write to o_m_tvalid. A stalled output register holds its data, and the FIFOs absorb beats until full.

module ipsxe_fp_join_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module ipsxe_floating_point_axi4s_join_v1_0 #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TLAST_MODE = 0,
  parameter int TLAST_SEL  = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_s_tvalid,
  output logic [NUM_CH-1:0]        o_s_tready,
  input  logic [NUM_CH*DATA_W-1:0] i_s_tdata,
  input  logic [NUM_CH-1:0]        i_s_tlast,
  output logic                     o_m_tvalid,
  input  logic                     i_m_tready,
  output logic [NUM_CH*DATA_W-1:0] o_m_tdata,
  output logic                     o_m_tlast,
  output logic                     o_tlast_mismatch,
  output logic [NUM_CH-1:0]        o_fifo_empty
);
  localparam int EW = DATA_W + 1;

  logic [NUM_CH-1:0]        full, empty, head_last, push;
  logic [NUM_CH*DATA_W-1:0] head_dat;
  logic                     fire, tlast_pol, tlast_diff;

  logic                     m_tvalid_q, m_tvalid_d;
  logic                     m_tlast_q, m_tlast_d;
  logic                     mismatch_q, mismatch_d;
  logic [NUM_CH*DATA_W-1:0] m_tdata_q, m_tdata_d;

  assign o_s_tready = ~full & {NUM_CH{~i_rst}};
  assign push       = i_s_tvalid & o_s_tready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [EW-1:0] head_entry;

    ipsxe_fp_join_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .push_i     (push[k]),
      .push_dat_i ({i_s_tlast[k], i_s_tdata[k*DATA_W +: DATA_W]}),
      .pop_i      (fire),
      .head_dat_o (head_entry),
      .empty_o    (empty[k]),
      .full_o     (full[k])
    );

    assign head_dat[k*DATA_W +: DATA_W] = head_entry[DATA_W-1:0];
    assign head_last[k]                 = head_entry[DATA_W];
  end

  // Pop only when every channel has a head entry and the output register can take it.
  assign fire       = (&(~empty)) & (~m_tvalid_q | i_m_tready);
  assign tlast_diff = (|head_last) & ~(&head_last);

  always_comb begin
    case (TLAST_MODE)
      1:       tlast_pol = |head_last;
      2:       tlast_pol = &head_last;
      default: tlast_pol = head_last[TLAST_SEL];
    endcase
  end

  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    mismatch_d = mismatch_q | (fire & tlast_diff);
    if (fire) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = head_dat;
      m_tlast_d  = tlast_pol;
    end else if (i_m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign o_m_tvalid       = m_tvalid_q;
  assign o_m_tdata        = m_tdata_q;
  assign o_m_tlast        = m_tlast_q;
  assign o_tlast_mismatch = mismatch_q;
  assign o_fifo_empty     = empty;
endmodule

// File: tb/tb_ipsxe_floating_point_axi4s_join_v1_0.sv
// Bench for the operand join: three instances differing only in TLAST policy share one stimulus.
// A queue-based model joins the n-th beat of every channel and scores the output stream in order.
module tb_ipsxe_floating_point_axi4s_join_v1_0;
  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [N-1:0]   s_vld = '0, s_last = '0;
  logic [N*W-1:0] s_dat = '0;
  logic           m_rdy = 1'b1;

  logic [N-1:0]   rdy0, rdy1, rdy2, emp0, emp1, emp2;
  logic           vld0, vld1, vld2, last0, last1, last2, mm0, mm1, mm2;
  logic [N*W-1:0] dat0, dat1, dat2;

  ipsxe_floating_point_axi4s_join_v1_0 #(.NUM_CH(N), .DATA_W(W), .FIFO_DEPTH(D), .TLAST_MODE(0), .TLAST_SEL(2)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_s_tvalid(s_vld), .o_s_tready(rdy0), .i_s_tdata(s_dat), .i_s_tlast(s_last),
    .o_m_tvalid(vld0), .i_m_tready(m_rdy), .o_m_tdata(dat0), .o_m_tlast(last0), .o_tlast_mismatch(mm0), .o_fifo_empty(emp0));
  ipsxe_floating_point_axi4s_join_v1_0 #(.NUM_CH(N), .DATA_W(W), .FIFO_DEPTH(D), .TLAST_MODE(1), .TLAST_SEL(0)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_s_tvalid(s_vld), .o_s_tready(rdy1), .i_s_tdata(s_dat), .i_s_tlast(s_last),
    .o_m_tvalid(vld1), .i_m_tready(m_rdy), .o_m_tdata(dat1), .o_m_tlast(last1), .o_tlast_mismatch(mm1), .o_fifo_empty(emp1));
  ipsxe_floating_point_axi4s_join_v1_0 #(.NUM_CH(N), .DATA_W(W), .FIFO_DEPTH(D), .TLAST_MODE(2), .TLAST_SEL(0)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_s_tvalid(s_vld), .o_s_tready(rdy2), .i_s_tdata(s_dat), .i_s_tlast(s_last),
    .o_m_tvalid(vld2), .i_m_tready(m_rdy), .o_m_tdata(dat2), .o_m_tlast(last2), .o_tlast_mismatch(mm2), .o_fifo_empty(emp2));

  logic [W:0]     src_q [N][$];
  logic [W:0]     ch_q  [N][$];
  logic [N*W-1:0] exp_dat[$], got_dat[$];
  logic [2:0]     exp_last[$], got_last[$];
  logic           model_mm = 1'b0;
  int checks = 0, passed = 0;

  function automatic bit all_have();
    for (int k = 0; k < N; k++) if (ch_q[k].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Model: accepted beats go into per-channel queues; the n-th joined beat is the n-th of each.
  always @(negedge clk) begin
    logic [N*W-1:0] jd;
    logic [N-1:0]   tl;
    logic [W:0]     e;
    if (!rst) begin
      for (int k = 0; k < N; k++)
        if (s_vld[k] && rdy0[k] && src_q[k].size() > 0) ch_q[k].push_back(src_q[k].pop_front());
      if (vld0 && m_rdy) begin
        got_dat.push_back(dat0);
        got_last.push_back({last2, last1, last0});
      end
      while (all_have()) begin
        for (int k = 0; k < N; k++) begin
          e = ch_q[k].pop_front();
          jd[k*W +: W] = e[W-1:0];
          tl[k] = e[W];
        end
        exp_dat.push_back(jd);
        exp_last.push_back({&tl, |tl, tl[2]});
        if (tl != '0 && tl != '1) model_mm = 1'b1;
      end
    end
  end

  task automatic step_en(input logic [N-1:0] en);
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0 && en[k]) begin
        s_vld[k]         = 1'b1;
        s_dat[k*W +: W]  = src_q[k][0][W-1:0];
        s_last[k]        = src_q[k][0][W];
      end else begin
        s_vld[k] = 1'b0;
      end
    end
  endtask

  task automatic step();
    step_en('1);
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      ch_q[k].delete();
    end
    exp_dat.delete(); exp_last.delete(); got_dat.delete(); got_last.delete();
    model_mm = 1'b0;
    s_vld = '0;
  endtask

  task automatic load_random(input int n, input logic rand_last);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < N; k++)
        src_q[k].push_back({rand_last ? 1'($urandom_range(0, 1)) : 1'b0, W'($urandom)});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_all();
    #1;
    checks++; if (rdy0 !== '0) $display("FAIL reset_tready_low got=%h want=0", rdy0); else passed++;
    step(); step();
    checks++; if ({vld0, dat0, last0, mm0} !== '0) $display("FAIL reset_outputs got vld=%b dat=%h last=%b mm=%b want all 0", vld0, dat0, last0, mm0); else passed++;
    checks++; if (emp0 !== 4'hf) $display("FAIL reset_empty got=%h want=f", emp0); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (rdy0 !== 4'hf) $display("FAIL reset_tready_after got=%h want=f", rdy0); else passed++;
  endtask

  task automatic test_basic();
    clear_all();
    m_rdy = 1'b1;
    for (int k = 0; k < N; k++) src_q[k].push_back({1'b0, 32'h11111111 * (k + 1)});
    step();
    checks++; if (vld0 !== 1'b0) $display("FAIL basic_vld_e0 got=%b want=0", vld0); else passed++;
    step();
    checks++; if (vld0 !== 1'b0) $display("FAIL basic_vld_e1 got=%b want=0", vld0); else passed++;
    step();
    checks++; if (vld0 !== 1'b1 || dat0 !== 128'h44444444_33333333_22222222_11111111)
      $display("FAIL basic_beat got vld=%b dat=%h want vld=1 dat=44444444333333332222222211111111", vld0, dat0); else passed++;
    step(); step();
    checks++; if (vld0 !== 1'b0 || got_dat.size() != 1) $display("FAIL basic_single got vld=%b beats=%0d want 0/1", vld0, got_dat.size()); else passed++;
  endtask

  task automatic test_skew();
    int early = 0;
    clear_all();
    m_rdy = 1'b1;
    for (int i = 1; i <= 3; i++) src_q[0].push_back({1'b0, W'(i)});
    for (int c = 0; c < 10; c++) begin
      step();
      if (vld0) early++;
    end
    checks++; if (early != 0) $display("FAIL skew_early_valid got=%0d cycles want=0", early); else passed++;
    for (int i = 0; i < 3; i++) for (int k = 1; k < N; k++) src_q[k].push_back({1'b0, W'($urandom)});
    for (int c = 0; c < 40 && got_dat.size() < 3; c++) step();
    checks++; if (got_dat.size() != 3) $display("FAIL skew_count got=%0d want=3", got_dat.size()); else passed++;
    for (int i = 0; i < got_dat.size() && i < exp_dat.size(); i++) begin
      checks++;
      if (got_dat[i] !== exp_dat[i] || got_dat[i][W-1:0] !== W'(i + 1))
        $display("FAIL skew_beat%0d got=%h want=%h", i, got_dat[i], exp_dat[i]); else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] held = '0;
    int unstable = 0;
    bit seen = 0;
    clear_all();
    m_rdy = 1'b0;
    load_random(6, 1'b0);
    for (int c = 0; c < 12; c++) begin
      step();
      if (vld0 && !seen) begin held = dat0; seen = 1; end
      else if (seen && dat0 !== held) unstable++;
    end
    checks++; if (rdy0 !== '0 || src_q[0].size() != 1) $display("FAIL bp_stall got rdy=%h pending=%0d want 0/1", rdy0, src_q[0].size()); else passed++;
    checks++; if (vld0 !== 1'b1 || unstable != 0 || exp_dat.size() == 0 || dat0 !== exp_dat[0])
      $display("FAIL bp_hold got vld=%b unstable=%0d dat=%h", vld0, unstable, dat0); else passed++;
    m_rdy = 1'b1;
    for (int c = 0; c < 60 && got_dat.size() < 6; c++) step();
    checks++; if (got_dat.size() != 6) $display("FAIL bp_count got=%0d want=6", got_dat.size()); else passed++;
    for (int i = 0; i < got_dat.size() && i < exp_dat.size(); i++) begin
      checks++;
      if (got_dat[i] !== exp_dat[i]) $display("FAIL bp_beat%0d got=%h want=%h", i, got_dat[i], exp_dat[i]); else passed++;
    end
  endtask

  task automatic test_tlast();
    logic [3:0] pat;
    clear_all();
    m_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pat = (i == 0) ? 4'b0101 : 4'b0000;
      for (int k = 0; k < N; k++) src_q[k].push_back({pat[k], W'($urandom)});
    end
    for (int c = 0; c < 40 && got_dat.size() < 3; c++) step();
    checks++; if (got_dat.size() != 3) $display("FAIL tlast_count got=%0d want=3", got_dat.size()); else passed++;
    checks++; if (got_last.size() < 1 || got_last[0] !== 3'b011) $display("FAIL tlast_policy got(and,or,sel)=%b want=011", got_last.size() ? got_last[0] : 3'bx); else passed++;
    for (int i = 0; i < got_dat.size() && i < exp_dat.size(); i++) begin
      checks++;
      if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i])
        $display("FAIL tlast_beat%0d got=%h/%b want=%h/%b", i, got_dat[i], got_last[i], exp_dat[i], exp_last[i]); else passed++;
    end
    checks++; if ({mm2, mm1, mm0} !== 3'b111 || model_mm !== 1'b1) $display("FAIL tlast_mismatch got=%b want=111", {mm2, mm1, mm0}); else passed++;
  endtask

  task automatic test_reset_mid();
    m_rdy = 1'b0;
    clear_all();
    load_random(4, 1'b0);
    for (int c = 0; c < 8; c++) step();
    checks++; if (vld0 !== 1'b1 || emp0 !== 4'h0) $display("FAIL rmid_pre got vld=%b empty=%h want 1/0", vld0, emp0); else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_all();
    #1;
    checks++; if (rdy0 !== '0) $display("FAIL rmid_tready_in_reset got=%h want=0", rdy0); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (vld0 !== 1'b0 || emp0 !== 4'hf || mm0 !== 1'b0) $display("FAIL rmid_cleared got vld=%b empty=%h mm=%b", vld0, emp0, mm0); else passed++;
    checks++; if (rdy0 !== 4'hf) $display("FAIL rmid_tready_after got=%h want=f", rdy0); else passed++;
    m_rdy = 1'b1;
    load_random(1, 1'b0);
    for (int c = 0; c < 20; c++) step();
    checks++; if (got_dat.size() != 1 || exp_dat.size() != 1 || got_dat[0] !== exp_dat[0])
      $display("FAIL rmid_fresh got beats=%0d first=%h", got_dat.size(), got_dat.size() ? got_dat[0] : 'x); else passed++;
  endtask

  task automatic test_throughput();
    int first = -1, last = -1, notrdy = 0, bad = 0;
    clear_all();
    m_rdy = 1'b1;
    load_random(100, 1'b0);
    for (int c = 0; c < 110; c++) begin
      step();
      if (rdy0 !== 4'hf) notrdy++;
      if (vld0) begin
        if (first < 0) first = c;
        last = c;
      end
    end
    checks++; if (got_dat.size() != 100) $display("FAIL tput_count got=%0d want=100", got_dat.size()); else passed++;
    checks++; if (last - first + 1 != 100) $display("FAIL tput_span got=%0d want=100", last - first + 1); else passed++;
    checks++; if (notrdy != 0) $display("FAIL tput_full got=%0d cycles want=0", notrdy); else passed++;
    for (int i = 0; i < got_dat.size() && i < exp_dat.size(); i++) if (got_dat[i] !== exp_dat[i]) bad++;
    checks++; if (bad != 0) $display("FAIL tput_data got=%0d bad beats want=0", bad); else passed++;
  endtask

  task automatic test_random();
    int diverge = 0, bad = 0;
    clear_all();
    load_random(60, 1'b1);
    for (int c = 0; c < 400; c++) begin
      m_rdy = ($urandom_range(0, 3) != 0);
      step_en(N'($urandom_range(0, 15)));
      if ({vld1, vld2} !== {2{vld0}} || dat1 !== dat0 || dat2 !== dat0 || rdy1 !== rdy0 || rdy2 !== rdy0 ||
          emp1 !== emp0 || emp2 !== emp0 || mm1 !== mm0 || mm2 !== mm0) diverge++;
    end
    m_rdy = 1'b1;
    for (int c = 0; c < 200 && got_dat.size() < 60; c++) step();
    checks++; if (got_dat.size() != 60) $display("FAIL rand_count got=%0d want=60", got_dat.size()); else passed++;
    for (int i = 0; i < got_dat.size() && i < exp_dat.size(); i++)
      if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i]) bad++;
    checks++; if (bad != 0) $display("FAIL rand_data got=%0d bad beats want=0", bad); else passed++;
    checks++; if (mm0 !== model_mm) $display("FAIL rand_mismatch got=%b want=%b", mm0, model_mm); else passed++;
    checks++; if (diverge != 0) $display("FAIL rand_policy_only got=%0d diverging cycles want=0", diverge); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skew();
    test_backpressure();
    test_tlast();
    test_reset_mid();
    test_throughput();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ipsxe_floating_point_axi4s_join_v1_0.md
Name: ipsxe_floating_point_axi4s_join_v1_0

Overview:
Parametrised AXI4-Stream operand join for the floating-point core. It accepts NUM_CH independent operand channels, such as A/B/C/OPERATION, each buffered in its own FIFO. When every channel holds a beat, it pops all channels together and presents one combined, registered beat to the arithmetic datapath. Output TLAST is derived per a configurable policy, and the block flags inconsistent TLASTs across channels.

Parameters:
NUM_CH, 4, number of input channels (1..4).
DATA_W, 32, tdata width per channel (1..64).
FIFO_DEPTH, 4, entries per channel FIFO (power of 2, 2..16).
TLAST_MODE, 0, 0 = pass channel TLAST_SEL; 1 = OR of all TLASTs; 2 = AND of all TLASTs.
TLAST_SEL, 0, source channel index for TLAST_MODE 0 (0..NUM_CH-1).

Ports:
i_clk  input  1  clock.
i_rst  input  1  synchronous active-high reset.
i_s_tvalid  input  NUM_CH  per-channel valid; bit k = channel k.
o_s_tready  output  NUM_CH  per-channel ready.
i_s_tdata  input  NUM_CH*DATA_W  channel k in bits [k*DATA_W +: DATA_W].
i_s_tlast  input  NUM_CH  per-channel TLAST.
o_m_tvalid  output  1  joined beat valid.
i_m_tready  input  1  downstream ready.
o_m_tdata  output  NUM_CH*DATA_W  joined data, same packing as input.
o_m_tlast  output  1  policy-derived TLAST.
o_tlast_mismatch  output  1  sticky flag: a joined beat had non-identical TLASTs.
o_fifo_empty  output  NUM_CH  per-channel FIFO empty status.

Behaviour:
- Reset (i_rst high at a rising edge of i_clk): all FIFOs are emptied (pointers and counts = 0).
  - Output values after reset: o_m_tvalid=0, o_m_tdata=0, o_m_tlast=0, o_tlast_mismatch=0, o_fifo_empty=all 1s.
  - o_s_tready is forced to 0 in any cycle where i_rst=1.
  - A reset mid-packet discards all buffered and output-register beats. No beat is emitted afterwards from pre-reset data.
- Channel k write: push occurs when i_s_tvalid[k] & o_s_tready[k]; data and tlast are stored together.
  - o_s_tready[k] = ~full[k] & ~i_rst, combinational from the registered count.
  - A full FIFO does not accept a push in the same cycle as a pop; ready reopens the cycle after the pop.
- Each channel keeps a count of width clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Join fire condition: fire = all FIFOs non-empty & (~o_m_tvalid | i_m_tready).
  - On fire, all NUM_CH FIFOs pop exactly one entry in the same cycle.
  - The output register loads the concatenated head data and the policy TLAST, and o_m_tvalid=1.
- If o_m_tvalid & i_m_tready & ~fire, then o_m_tvalid becomes 0. o_m_tdata and o_m_tlast hold their last values.
- While o_m_tvalid & ~i_m_tready, o_m_tdata and o_m_tlast are held stable.
- Throughput is one joined beat per cycle when every channel is continuously supplied and i_m_tready=1.
- Latency: a beat accepted at edge E into an empty FIFO, with the others already non-empty, appears with o_m_tvalid=1 after edge E+1.
- TLAST policy is evaluated on the popped head entries:
  - mode 0: tlast[TLAST_SEL];
  - mode 1: OR of all;
  - mode 2: AND of all.
- Mismatch: on fire, if the popped tlasts are not all equal, o_tlast_mismatch is set. It is cleared only by reset. With NUM_CH=1 it is never set.
- Channels are never reordered or dropped. The joined beat n always consists of the n-th beat of every channel.

Test Plan:
- Reset, then NUM_CH=4, DATA_W=32, i_m_tready=1; ch0..3 each send one beat 0x11111111/0x22222222/0x33333333/0x44444444 in the same cycle -> o_m_tvalid=1 two edges later; o_m_tdata=0x44444444_33333333_22222222_11111111; one beat only.
- Skewed arrival: ch0 sends 3 beats 1,2,3 at t=0; ch1..3 send theirs at t=10 -> no o_m_tvalid before the ch1..3 beats arrive; output order is 1,2,3, each paired with the matching beats of ch1..3.
- Backpressure: i_m_tready=0, with 6 beats offered on all channels at FIFO_DEPTH=4 -> the output register holds beat 1; the FIFOs absorb beats 2..5, so o_s_tready=0 after the 5th accept; beat 6 stalls. Release i_m_tready -> beats 1..6 emerge in order, data stable throughout the stall.
- TLAST policy: tlast pattern {ch3..0}=4'b0101 on one joined beat -> mode 0/TLAST_SEL=2 gives 1; mode 1 gives 1; mode 2 gives 0; o_tlast_mismatch=1 in all modes and it stays 1 on later beats with pattern 4'b0000.
- Reset mid-operation: FIFOs holding 3 beats and o_m_tvalid=1, assert i_rst for 1 cycle -> o_m_tvalid=0, o_fifo_empty=4'b1111, o_s_tready=0 during reset and all 1s after; the next output is only fresh post-reset data.
- Full throughput: all channels valid every cycle and i_m_tready=1 for 100 cycles -> 99 or more joined beats with o_m_tvalid continuously 1 after the initial fill, and no FIFO ever reporting full.
